// File: rtl/ddr3_timer_bank.sv
// Bank of independent down-counting delay timers for the DDR3 controller.
// Each channel runs one-shot or periodic (auto-reload) and emits a one-cycle
// registered expired pulse; a global pause freezes all decrements.
module ddr3_timer_bank #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned WIDTH  = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NUM_CH-1:0]       load,
   input  logic [NUM_CH*WIDTH-1:0] load_val,
   input  logic [NUM_CH-1:0]       periodic,
   input  logic [NUM_CH-1:0]       clear,
   input  logic                    pause,
   output logic [NUM_CH*WIDTH-1:0] count,
   output logic [NUM_CH-1:0]       busy,
   output logic [NUM_CH-1:0]       expired,
   output logic                    any_busy
);

   typedef enum logic {StIdle, StRun} state_e;

   state_e                  state_q [NUM_CH];
   state_e                  state_d [NUM_CH];
   logic [NUM_CH*WIDTH-1:0] count_q, count_d;
   logic [NUM_CH*WIDTH-1:0] reload_q, reload_d;
   logic [NUM_CH-1:0]       mode_q, mode_d;
   logic [NUM_CH-1:0]       expired_q, expired_d;

   // Per-channel next state: clear beats load, load beats decrement.
   always_comb begin
      count_d   = count_q;
      reload_d  = reload_q;
      mode_d    = mode_q;
      expired_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         state_d[i] = state_q[i];
         if (clear[i]) begin
            state_d[i]                 = StIdle;
            count_d[i*WIDTH +: WIDTH] = '0;
         end else if (load[i]) begin
            if (load_val[i*WIDTH +: WIDTH] != '0) begin
               count_d[i*WIDTH +: WIDTH]  = load_val[i*WIDTH +: WIDTH];
               reload_d[i*WIDTH +: WIDTH] = load_val[i*WIDTH +: WIDTH];
               mode_d[i]                  = periodic[i];
               state_d[i]                 = StRun;
            end else begin
               // Zero delay: expire immediately without entering RUN.
               expired_d[i]               = 1'b1;
               state_d[i]                 = StIdle;
               count_d[i*WIDTH +: WIDTH] = '0;
            end
         end else if (state_q[i] == StRun && !pause) begin
            if (count_q[i*WIDTH +: WIDTH] == WIDTH'(1)) begin
               expired_d[i] = 1'b1;
               if (mode_q[i]) begin
                  count_d[i*WIDTH +: WIDTH] = reload_q[i*WIDTH +: WIDTH];
               end else begin
                  count_d[i*WIDTH +: WIDTH] = '0;
                  state_d[i]                 = StIdle;
               end
            end else begin
               count_d[i*WIDTH +: WIDTH] = count_q[i*WIDTH +: WIDTH] - WIDTH'(1);
            end
         end
      end
   end

   // State registers with asynchronous reset that aborts every channel.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= StIdle;
         end
         count_q   <= '0;
         reload_q  <= '0;
         mode_q    <= '0;
         expired_q <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= state_d[i];
         end
         count_q   <= count_d;
         reload_q  <= reload_d;
         mode_q    <= mode_d;
         expired_q <= expired_d;
      end
   end

   // Status outputs decoded from the state registers.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         busy[i] = (state_q[i] == StRun);
      end
   end

   assign any_busy = |busy;
   assign count    = count_q;
   assign expired  = expired_q;

endmodule

// File: tb/tb_ddr3_timer_bank.sv
// Self-checking bench for ddr3_timer_bank (NUM_CH=4, WIDTH=16): table of
// per-cycle vectors fed through a scoreboard queue, plus hand sequences for
// asynchronous reset and the full-width delay.
module tb_ddr3_timer_bank;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  load = '0;
   logic [63:0] load_val = '0;
   logic [3:0]  periodic = '0;
   logic [3:0]  clear = '0;
   logic        pause = 1'b0;
   logic [63:0] count;
   logic [3:0]  busy;
   logic [3:0]  expired;
   logic        any_busy;

   ddr3_timer_bank #(
      .NUM_CH (4),
      .WIDTH  (16)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .load     (load),
      .load_val (load_val),
      .periodic (periodic),
      .clear    (clear),
      .pause    (pause),
      .count    (count),
      .busy     (busy),
      .expired  (expired),
      .any_busy (any_busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [3:0]  ld;
      logic [63:0] lv;
      logic [3:0]  per;
      logic [3:0]  clr;
      logic        pse;
      logic [63:0] cnt;
      logic [3:0]  bsy;
      logic [3:0]  ex;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   localparam logic [63:0] Z = '0;

   function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
      return {16'(d), 16'(c), 16'(b), 16'(a)};
   endfunction

   task automatic add(input logic [3:0] ld, input logic [63:0] lv, input logic [3:0] per,
                      input logic [3:0] clr, input logic pse, input logic [63:0] cnt,
                      input logic [3:0] bsy, input logic [3:0] ex);
      vec_t v;
      v.ld = ld; v.lv = lv; v.per = per; v.clr = clr; v.pse = pse;
      v.cnt = cnt; v.bsy = bsy; v.ex = ex;
      tbl.push_back(v);
   endtask

   task automatic nop(input logic [63:0] cnt, input logic [3:0] bsy, input logic [3:0] ex);
      add(4'b0000, Z, 4'b0000, 4'b0000, 1'b0, cnt, bsy, ex);
   endtask

   task automatic check(input string name, input int idx, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      vec_t e;
      int   seen;
      logic any_exp;

      // ---------------- asynchronous reset ----------------
      #2;
      check("reset_count", 0, count, Z);
      check("reset_busy", 0, 64'(busy), 64'(0));
      check("reset_expired", 0, 64'(expired), 64'(0));
      check("reset_any", 0, 64'(any_busy), 64'(0));
      tick();
      reset = 1'b0;
      load = 4'b0001; load_val = pk(10, 0, 0, 0);
      tick();
      load = '0; load_val = '0;
      tick(); tick(); tick();
      check("pre_reset_count", 1, count, pk(7, 0, 0, 0));
      #2 reset = 1'b1;
      #1;
      check("midreset_count", 1, count, Z);
      check("midreset_busy", 1, 64'(busy), 64'(0));
      check("midreset_any", 1, 64'(any_busy), 64'(0));
      tick();
      reset = 1'b0;
      any_exp = 1'b0;
      for (int n = 0; n < 14; n++) begin
         tick();
         any_exp = any_exp | (|expired) | any_busy;
      end
      check("post_reset_quiet", 2, 64'(any_exp), 64'(0));

      // ---------------- vector table ----------------
      // One-shot channel 1, delay 5.
      add(4'b0010, pk(0, 5, 0, 0), 4'b0000, 4'b0000, 1'b0, pk(0, 5, 0, 0), 4'b0010, 4'b0000);
      nop(pk(0, 4, 0, 0), 4'b0010, 4'b0000);
      nop(pk(0, 3, 0, 0), 4'b0010, 4'b0000);
      nop(pk(0, 2, 0, 0), 4'b0010, 4'b0000);
      nop(pk(0, 1, 0, 0), 4'b0010, 4'b0000);
      nop(Z, 4'b0000, 4'b0010);
      nop(Z, 4'b0000, 4'b0000);
      // Periodic channel 2, delay 3, paused on edges 5 and 6.
      add(4'b0100, pk(0, 0, 3, 0), 4'b0100, 4'b0000, 1'b0, pk(0, 0, 3, 0), 4'b0100, 4'b0000);
      nop(pk(0, 0, 2, 0), 4'b0100, 4'b0000);
      nop(pk(0, 0, 1, 0), 4'b0100, 4'b0000);
      nop(pk(0, 0, 3, 0), 4'b0100, 4'b0100);
      nop(pk(0, 0, 2, 0), 4'b0100, 4'b0000);
      add(4'b0000, Z, 4'b0000, 4'b0000, 1'b1, pk(0, 0, 2, 0), 4'b0100, 4'b0000);
      add(4'b0000, Z, 4'b0000, 4'b0000, 1'b1, pk(0, 0, 2, 0), 4'b0100, 4'b0000);
      nop(pk(0, 0, 1, 0), 4'b0100, 4'b0000);
      nop(pk(0, 0, 3, 0), 4'b0100, 4'b0100);
      nop(pk(0, 0, 2, 0), 4'b0100, 4'b0000);
      nop(pk(0, 0, 1, 0), 4'b0100, 4'b0000);
      nop(pk(0, 0, 3, 0), 4'b0100, 4'b0100);
      add(4'b0000, Z, 4'b0000, 4'b0100, 1'b0, Z, 4'b0000, 4'b0000);
      // Reload channel 0 on its terminal edge: old delay never fires.
      add(4'b0001, pk(4, 0, 0, 0), 4'b0000, 4'b0000, 1'b0, pk(4, 0, 0, 0), 4'b0001, 4'b0000);
      nop(pk(3, 0, 0, 0), 4'b0001, 4'b0000);
      nop(pk(2, 0, 0, 0), 4'b0001, 4'b0000);
      nop(pk(1, 0, 0, 0), 4'b0001, 4'b0000);
      add(4'b0001, pk(7, 0, 0, 0), 4'b0000, 4'b0000, 1'b0, pk(7, 0, 0, 0), 4'b0001, 4'b0000);
      for (int c = 6; c >= 1; c--) nop(pk(c, 0, 0, 0), 4'b0001, 4'b0000);
      nop(Z, 4'b0000, 4'b0001);
      nop(Z, 4'b0000, 4'b0000);
      // Clear with load on channel 3's terminal edge.
      add(4'b1000, pk(0, 0, 0, 2), 4'b0000, 4'b0000, 1'b0, pk(0, 0, 0, 2), 4'b1000, 4'b0000);
      nop(pk(0, 0, 0, 1), 4'b1000, 4'b0000);
      add(4'b1000, pk(0, 0, 0, 9), 4'b0000, 4'b1000, 1'b0, Z, 4'b0000, 4'b0000);
      nop(Z, 4'b0000, 4'b0000);
      // Zero-delay load on channel 1.
      add(4'b0010, Z, 4'b0000, 4'b0000, 1'b0, Z, 4'b0000, 4'b0010);
      nop(Z, 4'b0000, 4'b0000);
      // All four channels with delays 1..4.
      add(4'b1111, pk(1, 2, 3, 4), 4'b0000, 4'b0000, 1'b0, pk(1, 2, 3, 4), 4'b1111, 4'b0000);
      nop(pk(0, 1, 2, 3), 4'b1110, 4'b0001);
      nop(pk(0, 0, 1, 2), 4'b1100, 4'b0010);
      nop(pk(0, 0, 0, 1), 4'b1000, 4'b0100);
      nop(Z, 4'b0000, 4'b1000);
      nop(Z, 4'b0000, 4'b0000);
      // Back-to-back reload while expired is high, then pause drops the pulse.
      add(4'b0001, pk(2, 0, 0, 0), 4'b0000, 4'b0000, 1'b0, pk(2, 0, 0, 0), 4'b0001, 4'b0000);
      nop(pk(1, 0, 0, 0), 4'b0001, 4'b0000);
      nop(Z, 4'b0000, 4'b0001);
      add(4'b0001, pk(1, 0, 0, 0), 4'b0000, 4'b0000, 1'b0, pk(1, 0, 0, 0), 4'b0001, 4'b0000);
      nop(Z, 4'b0000, 4'b0001);
      add(4'b0000, Z, 4'b0000, 4'b0000, 1'b1, Z, 4'b0000, 4'b0000);
      // Load and clear still act while paused.
      add(4'b0010, pk(0, 5, 0, 0), 4'b0000, 4'b0000, 1'b1, pk(0, 5, 0, 0), 4'b0010, 4'b0000);
      add(4'b0000, Z, 4'b0000, 4'b0000, 1'b1, pk(0, 5, 0, 0), 4'b0010, 4'b0000);
      add(4'b0000, Z, 4'b0000, 4'b0010, 1'b1, Z, 4'b0000, 4'b0000);

      for (int i = 0; i < tbl.size(); i++) begin
         load = tbl[i].ld; load_val = tbl[i].lv; periodic = tbl[i].per;
         clear = tbl[i].clr; pause = tbl[i].pse;
         sb.push_back(tbl[i]);
         tick();
         e = sb.pop_front();
         check("count", i, count, e.cnt);
         check("busy", i, 64'(busy), 64'(e.bsy));
         check("expired", i, 64'(expired), 64'(e.ex));
         check("any_busy", i, 64'(any_busy), 64'(|e.bsy));
      end
      load = '0; load_val = '0; periodic = '0; clear = '0; pause = 1'b0;

      // ---------------- full-width delay ----------------
      load = 4'b0001; load_val = pk(65535, 0, 0, 0);
      tick();
      load = '0; load_val = '0;
      check("ffff_count", 0, count, pk(65535, 0, 0, 0));
      seen = 0;
      for (int n = 1; n <= 65540 && seen == 0; n++) begin
         tick();
         if (expired[0]) seen = n;
      end
      check("ffff_edge", 0, 64'(seen), 64'(65535));
      tick();
      check("ffff_idle", 0, 64'({busy, expired}), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ddr3_timer_bank.md
# ddr3_timer_bank

Parametrised bank of independent down-counting delay timers for the DDR3 controller FSM. It enforces JEDEC timing parameters concurrently: tRCD, tRP, tWR, tRFC and the periodic tREFI refresh tick each run on their own channel. Each channel is loaded with a cycle count and pulses `expired` when the delay has elapsed. A channel runs either one-shot or periodic, auto-reloading for refresh scheduling. A global pause freezes all channels during controller stalls.

## Interface
Parameters:
- `NUM_CH`, 4: number of independent timer channels (1..16).
- `WIDTH`, 16: counter width per channel in bits (2..32).

Ports:
- `clock`  input  1  controller clock; all state changes on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `load`  input  NUM_CH  per-channel load strobe, sampled on the clock edge.
- `load_val`  input  NUM_CH*WIDTH  delay in cycles; channel i uses bits [i*WIDTH +: WIDTH].
- `periodic`  input  NUM_CH  mode, sampled with `load`: 1 selects auto-reload, 0 selects one-shot.
- `clear`  input  NUM_CH  per-channel abort strobe.
- `pause`  input  1  global hold; when high, no channel decrements.
- `count`  output  NUM_CH*WIDTH  current remaining count per channel, registered.
- `busy`  output  NUM_CH  channel is in the RUN state.
- `expired`  output  NUM_CH  single-cycle registered pulse marking delay elapsed.
- `any_busy`  output  1  OR of `busy`.

## Operation
- Per-channel state machine with two states, IDLE and RUN. Registered per-channel state: `count`, `reload` (WIDTH bits), `mode` (1 bit), `expired`.
- Priority each edge, per channel, highest first: `clear`, then `load`, then decrement.
- `clear`:
  - Effect: state goes to IDLE, `count` to 0, `expired` to 0.
  - Precedence: overrides a simultaneous `load` or a pending expiry, so no pulse is produced.
- `load` with V = `load_val` slice ≥ 1:
  - Effect: `count` takes V, `reload` takes V, `mode` takes `periodic`[i], state goes to RUN.
  - Load while in RUN restarts the channel with the new value. The old delay produces no `expired` pulse, even if it would have expired on this edge.
- `load` with V = 0:
  - Effect: `expired` pulses on this edge; state goes to or stays IDLE; `count` is 0.
  - This is the zero-delay case.
- Decrement: in RUN with `pause` low, `count` decrements by 1 each edge.
- Terminal edge (RUN, `pause` low, `count` == 1):
  - `expired` is set to 1 for exactly one cycle.
  - `mode` = 0: `count` goes to 0 and state goes to IDLE.
  - `mode` = 1: `count` takes `reload` and state stays RUN, so `count` never shows 0 in periodic mode.
- `pause` high:
  - `count` holds and no new expiry is generated.
  - `expired` still deasserts after its single cycle.
  - `load` and `clear` still take effect.
- `expired` is otherwise 0 on every edge.
- Arithmetic rules:
  - Unsigned, WIDTH bits.
  - Decrement never occurs from 0, because IDLE never decrements.
  - A `load_val` of all-ones is legal and gives a delay of 2^WIDTH−1 cycles.
- `busy`[i] = (state == RUN). `any_busy` is combinational from the state registers.
- Channels are fully independent. Simultaneous events on different channels do not interact.

## Timing
- Reset (asynchronous assert): `count`=0, `busy`=0, `expired`=0, `any_busy`=0, `reload`=0, `mode`=0.
- Reset mid-operation aborts all channels immediately, with no `expired` pulse.
- Latency from load:
  - Load of V ≥ 1 at edge k gives `count`=V and `busy`=1 after edge k.
  - With no pause, `expired` is high during the cycle following edge k+V, with `busy` falling at the same edge (one-shot).
- Pause stretches latency: each paused edge adds exactly one cycle.
- Periodic mode: `expired` pulses every V unpaused cycles, and the first pulse follows edge k+V.
- Back-to-back: reloading on the cycle `expired` is high is legal. The new run starts at that edge.
- All outputs are registered except `any_busy`. There is no combinational path from inputs to outputs.

## Test plan
- Reset and idle: assert `reset` mid-count on channel 0 loaded with 10 → all outputs 0 immediately, and no `expired` pulse ever appears.
- One-shot: NUM_CH=4, WIDTH=16; load channel 1 with 5 at edge 0 → `count`[1] reads 5,4,3,2,1 then 0; `expired`[1] is high for one cycle after edge 5; `busy`[1] falls at edge 5.
- Periodic with pause: load channel 2 with 3, `periodic`=1 → `expired`[2] after edges 3, 6, 9. Hold `pause` high for 2 cycles between edges 4 and 6 → pulses after edges 3, 8, 11.
- Priority:
  - Load channel 0 with 4, then re-load it with 7 on the edge where `count` is 1 → no pulse, and the next `expired` comes 7 edges later.
  - `clear` together with `load` on the same edge → channel IDLE, `count`=0.
- Corners:
  - `load_val`=0 → one-cycle `expired`, `busy` stays 0.
  - `load_val`=16'hFFFF → `expired` after exactly 65535 edges.
  - All four channels loaded on the same edge with values 1..4 → staggered pulses on consecutive edges; `any_busy` falls after edge 4.
